// File: rtl/inst_loader_if.sv
// Field-set stream into the instruction loader.
// Master drives decoded fields; slave returns In_Ready.
interface inst_loader_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int ADDR_WIDTH   = 6
);
  logic                    In_Valid;
  logic                    In_Ready;
  logic                    In_Last;
  logic [OPCODE_WIDTH-1:0] Opcode;
  logic [ADDR_WIDTH-1:0]   Source_Reg1;
  logic [ADDR_WIDTH-1:0]   Source_Reg2;
  logic [ADDR_WIDTH-1:0]   Dest_Reg;

  modport master (
    output In_Valid, In_Last, Opcode,
    output Source_Reg1, Source_Reg2, Dest_Reg,
    input  In_Ready
  );

  modport slave (
    input  In_Valid, In_Last, Opcode,
    input  Source_Reg1, Source_Reg2, Dest_Reg,
    output In_Ready
  );
endinterface

// File: rtl/inst_loader.sv
// Packs field sets into words and fills instruction RAM from address 0.
// Define INST_LOADER_VERIFY_EN to add a read-back check of every word.
module inst_loader #(
  parameter int INST_WIDTH     = 21,
  parameter int OPCODE_WIDTH   = 3,
  parameter int ADDR_WIDTH     = 6,
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int MEM_DEPTH      = 64
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  inst_loader_if.slave            in_bus,
  output logic                    Ram_Wr_En,
  output logic                    Ram_Rd_En,
  output logic [RAM_ADDR_WIDTH-1:0] Ram_Addr,
  output logic [INST_WIDTH-1:0]   Ram_Inst_In,
  input  logic [INST_WIDTH-1:0]   Ram_Inst_Out,
  output logic [RAM_ADDR_WIDTH:0] Count,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Full,
  output logic                    Verify_Err
);

  localparam logic [RAM_ADDR_WIDTH:0] DEPTH_C =
    (RAM_ADDR_WIDTH+1)'(MEM_DEPTH);

`ifdef INST_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, ACCEPT, WRITE, VRD, VCMP, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ACCEPT, WRITE, DONE
  } state_t;
`endif

  state_t state, state_nx;

  logic last_q;
  logic accept;
  logic advance;
  logic session_clr;
  logic mismatch;
  logic cnt_hit;

  assign cnt_hit = (Count + 1'b1) == DEPTH_C;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    advance     = 1'b0;
    session_clr = 1'b0;
    mismatch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          session_clr = 1'b1;
          state_nx    = ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_bus.In_Valid) begin
          accept   = 1'b1;
          state_nx = WRITE;
        end
      end
`ifdef INST_LOADER_VERIFY_EN
      WRITE: state_nx = VRD;
      VRD:   state_nx = VCMP;
      VCMP: begin
        advance  = 1'b1;
        mismatch = Ram_Inst_Out != Ram_Inst_In;
      end
`else
      WRITE: advance = 1'b1;
`endif
      default: state_nx = IDLE;
    endcase
    // The final word or a full RAM ends the session.
    if (advance)
      state_nx = (last_q || cnt_hit) ? DONE : ACCEPT;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Count       <= '0;
      Full        <= 1'b0;
      last_q      <= 1'b0;
      Ram_Addr    <= '0;
      Ram_Inst_In <= '0;
    end else begin
      if (session_clr) begin
        Count <= '0;
        Full  <= 1'b0;
      end
      if (accept) begin
        Ram_Inst_In <= {in_bus.Opcode, in_bus.Source_Reg1,
                        in_bus.Source_Reg2, in_bus.Dest_Reg};
        Ram_Addr    <= Count[RAM_ADDR_WIDTH-1:0];
        last_q      <= in_bus.In_Last;
      end
      if (advance) begin
        Count <= Count + 1'b1;
        Full  <= cnt_hit;
      end
    end
  end

`ifdef INST_LOADER_VERIFY_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)            Verify_Err <= 1'b0;
    else if (session_clr) Verify_Err <= 1'b0;
    else if (mismatch)    Verify_Err <= 1'b1;
  end

  assign Ram_Rd_En = state == VRD;
`else
  logic unused_rd;
  assign unused_rd  = ^{Ram_Inst_Out, mismatch};
  assign Verify_Err = 1'b0;
  assign Ram_Rd_En  = 1'b0;
`endif

  assign in_bus.In_Ready = state == ACCEPT;
  assign Ram_Wr_En       = state == WRITE;
  assign Done            = state == DONE;
  assign Busy            = state != IDLE && state != DONE;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a RAM model and
// a write scoreboard fed at stimulus time.
module tb_inst_loader;

`ifdef INST_LOADER_VERIFY_EN
  localparam int PER = 4;
`else
  localparam int PER = 2;
`endif

  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  always #5 Clk = ~Clk;

  inst_loader_if bus ();

  logic        Ram_Wr_En, Ram_Rd_En;
  logic [5:0]  Ram_Addr;
  logic [20:0] Ram_Inst_In;
  logic [20:0] Ram_Inst_Out = '0;
  logic [6:0]  Count;
  logic        Busy, Done, Full, Verify_Err;

  inst_loader dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .in_bus       (bus),
    .Ram_Wr_En    (Ram_Wr_En),
    .Ram_Rd_En    (Ram_Rd_En),
    .Ram_Addr     (Ram_Addr),
    .Ram_Inst_In  (Ram_Inst_In),
    .Ram_Inst_Out (Ram_Inst_Out),
    .Count        (Count),
    .Busy         (Busy),
    .Done         (Done),
    .Full         (Full),
    .Verify_Err   (Verify_Err)
  );

  logic [20:0] mem [64];
  logic        corrupt;

  always @(posedge Clk) begin
    if (Ram_Wr_En) mem[Ram_Addr] <= Ram_Inst_In;
    if (Ram_Rd_En)
      Ram_Inst_Out <= mem[Ram_Addr] ^
        ((corrupt && Ram_Addr == 6'd2) ? 21'h1 : 21'h0);
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int exp_ptr;

  always @(posedge Clk) cyc++;

  typedef struct {
    logic [5:0]  addr;
    logic [20:0] word;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin : mon
    exp_t e;
    if (Ram_Wr_En === 1'b1) begin
      chk("wr_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(Ram_Addr), 32'(e.addr));
        chk("wr_word", 32'(Ram_Inst_In), 32'(e.word));
      end
    end
  end

  task automatic start_session();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start   = 1'b0;
    t0      = cyc;
    exp_ptr = 0;
  endtask

  task automatic send(logic [2:0] op, logic [5:0] s1,
                      logic [5:0] s2, logic [5:0] d,
                      logic last);
    exp_t e;
    bit   ok;
    bus.In_Valid    = 1'b1;
    bus.In_Last     = last;
    bus.Opcode      = op;
    bus.Source_Reg1 = s1;
    bus.Source_Reg2 = s2;
    bus.Dest_Reg    = d;
    e.addr = exp_ptr[5:0];
    e.word = {op, s1, s2, d};
    sb.push_back(e);
    exp_ptr++;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge Clk);
      if (bus.In_Ready) begin
        @(posedge Clk);
        #1;
        ok = 1'b1;
      end
    end
    bus.In_Valid = 1'b0;
    bus.In_Last  = 1'b0;
    chk("accept_in_time", 32'(ok), 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 600) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("done_reached", 32'(Done), 1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.In_Ready && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("ready_reached", 32'(bus.In_Ready), 1);
  endtask

  initial begin
    int edges;
    Reset           = 1'b1;
    Start           = 1'b0;
    corrupt         = 1'b0;
    bus.In_Valid    = 1'b0;
    bus.In_Last     = 1'b0;
    bus.Opcode      = '0;
    bus.Source_Reg1 = '0;
    bus.Source_Reg2 = '0;
    bus.Dest_Reg    = '0;
    exp_ptr         = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", 32'(bus.In_Ready), 0);
    chk("rst_wr", 32'(Ram_Wr_En), 0);
    chk("rst_rd", 32'(Ram_Rd_En), 0);
    chk("rst_flags", 32'({Busy, Done, Full, Verify_Err}), 0);
    chk("rst_addr", 32'(Ram_Addr), 0);
    chk("rst_word", 32'(Ram_Inst_In), 0);
    chk("rst_count", 32'(Count), 0);
    Reset = 1'b0;

    // Start with In_Valid already high, then reset mid-WRITE
    bus.In_Valid    = 1'b1;
    bus.Opcode      = 3'd6;
    bus.Source_Reg1 = 6'd33;
    bus.Source_Reg2 = 6'd17;
    bus.Dest_Reg    = 6'd9;
    start_session();
    chk("start_no_wr", 32'(Ram_Wr_En), 0);
    chk("start_ready", 32'(bus.In_Ready), 1);
    chk("start_count", 32'(Count), 0);
    @(posedge Clk);
    #1;
    chk("mid_wr", 32'(Ram_Wr_En), 1);
    Reset        = 1'b1;
    bus.In_Valid = 1'b0;
    #1;
    chk("abort_wr", 32'(Ram_Wr_En), 0);
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_word", 32'(Ram_Inst_In), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("post_abort_busy", 32'(Busy), 0);

    // Three-word session, last flagged
    start_session();
    send(3'b101, 6'd1, 6'd2, 6'd3, 1'b0);
    send(3'b010, 6'd10, 6'd20, 6'd30, 1'b0);
    send(3'b111, 6'd63, 6'd0, 6'd45, 1'b1);
    chk("final_wr", 32'(Ram_Wr_En), 1);
    chk("final_not_done", 32'(Done), 0);
    wait_done(edges);
    chk("done_latency", 32'(edges), 32'(PER - 1));
    chk("ram0", 32'(mem[0]), 32'(21'b101_000001_000010_000011));
    chk("count3", 32'(Count), 3);
    chk("full3", 32'(Full), 0);
    chk("busy3", 32'(Busy), 0);
    chk("ready3", 32'(bus.In_Ready), 0);
    chk("addr_hold", 32'(Ram_Addr), 2);
    chk("verr3", 32'(Verify_Err), 0);

    // Gap of five idle cycles, then Start pulsed while busy
    start_session();
    send(3'd1, 6'd1, 6'd1, 6'd1, 1'b0);
    wait_ready();
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      chk("gap_count", 32'(Count), 1);
    end
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("ign_count", 32'(Count), 1);
    chk("ign_ready", 32'(bus.In_Ready), 1);
    chk("ign_busy", 32'(Busy), 1);
    send(3'd4, 6'd9, 6'd8, 6'd7, 1'b1);
    wait_done(edges);
    chk("gap_total", 32'(Count), 2);
    chk("ram1", 32'(mem[1]), 32'({3'd4, 6'd9, 6'd8, 6'd7}));

`ifdef INST_LOADER_VERIFY_EN
    corrupt = 1'b1;
    start_session();
    send(3'd1, 6'd4, 6'd5, 6'd6, 1'b0);
    send(3'd2, 6'd7, 6'd8, 6'd9, 1'b0);
    wait_ready();
    chk("verr_clean", 32'(Verify_Err), 0);
    send(3'd3, 6'd11, 6'd12, 6'd13, 1'b0);
    wait_ready();
    chk("verr_set", 32'(Verify_Err), 1);
    send(3'd4, 6'd14, 6'd15, 6'd16, 1'b1);
    wait_done(edges);
    chk("verr_sticky", 32'(Verify_Err), 1);
    corrupt = 1'b0;
    start_session();
    chk("verr_clear", 32'(Verify_Err), 0);
    send(3'd5, 6'd1, 6'd1, 6'd1, 1'b1);
    wait_done(edges);
    chk("verr_clean_run", 32'(Verify_Err), 0);
`endif

    // Fill the whole RAM without In_Last
    start_session();
    for (int i = 0; i < 64; i++)
      send(3'(i), 6'(i), ~6'(i), 6'(i) ^ 6'h2a, 1'b0);
    wait_done(edges);
    chk("fill_cycles", 32'(cyc - t0), 32'(PER * 64));
    chk("fill_full", 32'(Full), 1);
    chk("fill_count", 32'(Count), 64);
    chk("fill_ready", 32'(bus.In_Ready), 0);
    chk("ram63", 32'(mem[63]),
        32'({3'd7, 6'd63, 6'd0, 6'h15}));
    bus.In_Valid = 1'b1;
    bus.Opcode   = 3'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("stall_ready", 32'(bus.In_Ready), 0);
    end
    bus.In_Valid = 1'b0;
    chk("stall_count", 32'(Count), 64);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
